// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file constants and the writeback entry type.
package rv_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NREG = 32;
    localparam int XLEN_DEF = 32;
    localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries with async pointer reset.
module wb_fifo import rv_pkg::*; #(
    parameter int DEPTH = 4,
    parameter type T = wb_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign head  = mem[rp];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: arbitrates ALU and queued load results onto the single register-file
// write port and tracks pending loads for decode's load-use stall.
module rf_writeback import rv_pkg::*; #(
    parameter int XLEN = 32,
    parameter int LQ_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    output logic                  reg_wr,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [XLEN-1:0]       wdata,
    output logic [NREG-1:0]       busy
);
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } entry_t;
    entry_t head, win;
    logic full, empty, fifo_win, alu_win, push, any_win;
    logic [NREG-1:0] busy_n;
    assign alu_ready = !full;
    assign ld_ready  = !full;
    // A full queue must drain, otherwise ALU traffic could starve loads forever.
    assign fifo_win = full || (!alu_valid && !empty);
    assign alu_win  = alu_valid && !full;
    assign any_win  = fifo_win || alu_win;
    assign push     = ld_valid && !full;
    assign win      = fifo_win ? head : entry_t'{rd: alu_rd, data: alu_data};
    wb_fifo #(.DEPTH(LQ_DEPTH), .T(entry_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (fifo_win),
        .din   (entry_t'{rd: ld_rd, data: ld_data}),
        .head  (head),
        .full  (full),
        .empty (empty)
    );
    // Set after clear so a same-cycle re-issue keeps the register pending.
    always_comb begin
        busy_n = busy;
        if (fifo_win && head.rd != X0) busy_n[head.rd] = 1'b0;
        if (ld_issue && ld_issue_rd != X0) busy_n[ld_issue_rd] = 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wr <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
            busy   <= '0;
        end else begin
            reg_wr <= any_win && win.rd != X0;
            if (any_win) begin
                waddr <= win.rd;
                wdata <= win.data;
            end
            busy <= busy_n;
        end
    end
endmodule
